// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Brief    : Shared types and constants for the pipeline hazard controller
//             (FSM state encoding, register-index field positions, x0 index).
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Register index width and source-field positions in a RISC-V instruction
  localparam int REG_IDX_W = 5;
  localparam int RS1_LSB   = 15;
  localparam int RS2_LSB   = 20;

  // Hard-wired zero register; a write to it never creates a dependency
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  // Sequencer states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_cmp
//  Brief    : Combinational load-use comparator. Flags when the load in EX
//             writes a register read by the instruction in decode. Both source
//             fields are compared regardless of opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      instr,
  input  logic                 mem_read,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 load_use
);

  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 unused_instr_bits;

  assign rs1 = instr[RS1_LSB +: REG_IDX_W];
  assign rs2 = instr[RS2_LSB +: REG_IDX_W];

  // Opcode/funct/rd fields play no part in the comparison
  assign unused_instr_bits = ^{instr[XLEN-1:RS2_LSB+REG_IDX_W], instr[RS1_LSB-1:0]};

  // Hazard when a real (non-x0) load destination matches either source
  always_comb begin
    load_use = mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush sequencer for a 5-stage pipeline. Handles load-use
//             bubbles, taken-branch squashes and data-memory freezes with a
//             sticky timeout watchdog. Stall/flush outputs are Mealy.
//             Optional macro PIPE_CTRL_PERF_CNT_EN enables three saturating
//             performance counters; otherwise the counter ports read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int XLEN        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      instruction_IFID_in,
  input  logic                 memRead_IDEX_in,
  input  logic [REG_IDX_W-1:0] rd_IDEX_in,
  input  logic                 branchTaken_EX_in,
  input  logic                 memReq_EXMEM_in,
  input  logic                 memReady_in,
  output logic                 stallPC_out,
  output logic                 stall_disable_IFID_out,
  output logic                 stall_disable_IDEX_out,
  output logic                 stall_disable_EXMEM_out,
  output logic                 stall_disable_MEMWB_out,
  output logic                 flush_IFID_out,
  output logic                 flush_IDEX_out,
  output logic                 flush_EXMEM_out,
  output logic                 flush_MEMWB_out,
  output logic                 memTimeout_out,
  output logic [31:0]          cnt_loadUse_out,
  output logic [31:0]          cnt_memWait_out,
  output logic [31:0]          cnt_flush_out
);

  // Watchdog is wide enough to hold MEM_TIMEOUT and saturates there
  localparam int              WD_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W:0]   WD_LIM = (WD_W+1)'(MEM_TIMEOUT);

  pipe_state_e       state;
  pipe_state_e       state_next;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W:0]     wd_inc;
  logic              mem_timeout;
  logic              load_use;
  logic              mem_stall;
  logic              branch_flush;
  logic              lu_stall;

  pipe_hazard_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .instr    (instruction_IFID_in),
    .mem_read (memRead_IDEX_in),
    .rd       (rd_IDEX_in),
    .load_use (load_use)
  );

  // Event resolution: a memory freeze beats a branch, which beats load-use.
  // In MEM_WAIT only memReady matters; the ready cycle behaves like RUN so
  // the lower-priority events get evaluated as the pipeline moves.
  always_comb begin
    if (state == MEM_WAIT) begin
      mem_stall = !memReady_in;
    end else begin
      mem_stall = memReq_EXMEM_in && !memReady_in;
    end
    branch_flush = !mem_stall && branchTaken_EX_in;
    lu_stall     = !mem_stall && !branchTaken_EX_in && load_use;
    state_next   = mem_stall ? MEM_WAIT : RUN;
    wd_inc       = {1'b0, wd_cnt} + 1'b1;
  end

  // Mealy stall/flush decode; during reset every stage is bubbled
  always_comb begin
    stallPC_out             = 1'b0;
    stall_disable_IFID_out  = 1'b0;
    stall_disable_IDEX_out  = 1'b0;
    stall_disable_EXMEM_out = 1'b0;
    stall_disable_MEMWB_out = 1'b0;
    flush_IFID_out          = 1'b0;
    flush_IDEX_out          = 1'b0;
    flush_EXMEM_out         = 1'b0;
    flush_MEMWB_out         = 1'b0;
    if (!rst_n) begin
      flush_IFID_out  = 1'b1;
      flush_IDEX_out  = 1'b1;
      flush_EXMEM_out = 1'b1;
      flush_MEMWB_out = 1'b1;
    end else if (mem_stall) begin
      stallPC_out             = 1'b1;
      stall_disable_IFID_out  = 1'b1;
      stall_disable_IDEX_out  = 1'b1;
      stall_disable_EXMEM_out = 1'b1;
      flush_MEMWB_out         = 1'b1;
    end else if (branch_flush) begin
      flush_IFID_out = 1'b1;
      flush_IDEX_out = 1'b1;
    end else if (lu_stall) begin
      stallPC_out            = 1'b1;
      stall_disable_IFID_out = 1'b1;
      flush_IDEX_out         = 1'b1;
    end
  end

  // State register plus watchdog: counts stalled MEM_WAIT cycles, sticky flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == MEM_WAIT) && mem_stall) begin
        if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_inc[WD_W-1:0];
        end
        if (wd_inc >= WD_LIM) begin
          mem_timeout <= 1'b1;
        end
      end else if (state_next == RUN) begin
        wd_cnt <= '0;
      end
    end
  end

  assign memTimeout_out = mem_timeout;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cnt_lu;
  logic [31:0] cnt_mw;
  logic [31:0] cnt_fl;

  // Saturating event counters, one increment per cycle the event takes effect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lu <= '0;
      cnt_mw <= '0;
      cnt_fl <= '0;
    end else begin
      if (lu_stall && (cnt_lu != '1)) begin
        cnt_lu <= cnt_lu + 32'd1;
      end
      if (mem_stall && (cnt_mw != '1)) begin
        cnt_mw <= cnt_mw + 32'd1;
      end
      if (branch_flush && (cnt_fl != '1)) begin
        cnt_fl <= cnt_fl + 32'd1;
      end
    end
  end

  assign cnt_loadUse_out = cnt_lu;
  assign cnt_memWait_out = cnt_mw;
  assign cnt_flush_out   = cnt_fl;
`else
  assign cnt_loadUse_out = '0;
  assign cnt_memWait_out = '0;
  assign cnt_flush_out   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Scoreboard bench for pipe_hazard_ctrl. Directed scenarios then
//             random traffic; expected outputs come from a rule-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int TMO = 3;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        stall_pc;
    logic        s_ifid;
    logic        s_idex;
    logic        s_exmem;
    logic        s_memwb;
    logic        f_ifid;
    logic        f_idex;
    logic        f_exmem;
    logic        f_memwb;
    logic        tmo;
    logic [31:0] c_lu;
    logic [31:0] c_mw;
    logic [31:0] c_fl;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_read = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        br = 1'b0;
  logic        req = 1'b0;
  logic        rdy = 1'b1;

  logic stall_pc, s_ifid, s_idex, s_exmem, s_memwb;
  logic f_ifid, f_idex, f_exmem, f_memwb, tmo;
  logic [31:0] c_lu, c_mw, c_fl;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  // Reference state, expressed as the pipeline's situation rather than FSM bits
  bit          frozen_before = 1'b0;  // memory held the pipeline last cycle
  int          frozen_run = 0;        // consecutive frozen cycles after the first
  bit          m_tmo = 1'b0;
  logic [31:0] m_lu = '0, m_mw = '0, m_fl = '0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .XLEN(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .instruction_IFID_in     (instr),
    .memRead_IDEX_in         (mem_read),
    .rd_IDEX_in              (rd),
    .branchTaken_EX_in       (br),
    .memReq_EXMEM_in         (req),
    .memReady_in             (rdy),
    .stallPC_out             (stall_pc),
    .stall_disable_IFID_out  (s_ifid),
    .stall_disable_IDEX_out  (s_idex),
    .stall_disable_EXMEM_out (s_exmem),
    .stall_disable_MEMWB_out (s_memwb),
    .flush_IFID_out          (f_ifid),
    .flush_IDEX_out          (f_idex),
    .flush_EXMEM_out         (f_exmem),
    .flush_MEMWB_out         (f_memwb),
    .memTimeout_out          (tmo),
    .cnt_loadUse_out         (c_lu),
    .cnt_memWait_out         (c_mw),
    .cnt_flush_out           (c_fl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] r;
    r = $urandom;
    r[19:15] = rs1;
    r[24:20] = rs2;
    return r;
  endfunction

  function automatic logic sat_inc_ok(input logic [31:0] v);
    return v != 32'hFFFF_FFFF;
  endfunction

  // Apply one cycle of stimulus, push the expected response, advance the model
  task automatic cyc(input logic r, input logic [31:0] ins, input logic mr,
                     input logic [4:0] d, input logic b, input logic q, input logic y);
    obs_t e;
    bit   freeze, hazard, do_br, do_lu;
    @(posedge clk);
    #1;
    rst_n = r; instr = ins; mem_read = mr; rd = d; br = b; req = q; rdy = y;
    e = '0;
    e.tmo  = m_tmo;
    e.c_lu = PERF ? m_lu : 32'd0;
    e.c_mw = PERF ? m_mw : 32'd0;
    e.c_fl = PERF ? m_fl : 32'd0;
    if (!r) begin
      {e.f_ifid, e.f_idex, e.f_exmem, e.f_memwb} = 4'hF;
      frozen_before = 1'b0; frozen_run = 0; m_tmo = 1'b0;
      m_lu = '0; m_mw = '0; m_fl = '0;
    end else begin
      // once frozen, only memory readiness releases the pipeline
      freeze = frozen_before ? !y : (q && !y);
      hazard = mr && (d != 5'd0) && (d == ins[19:15] || d == ins[24:20]);
      do_br  = !freeze && b;
      do_lu  = !freeze && !b && hazard;
      if (freeze) begin
        {e.stall_pc, e.s_ifid, e.s_idex, e.s_exmem, e.f_memwb} = 5'h1F;
      end else if (do_br) begin
        {e.f_ifid, e.f_idex} = 2'b11;
      end else if (do_lu) begin
        {e.stall_pc, e.s_ifid, e.f_idex} = 3'b111;
      end
      if (frozen_before && freeze) begin
        frozen_run++;
        if (frozen_run >= TMO) m_tmo = 1'b1;
      end else begin
        frozen_run = 0;
      end
      frozen_before = freeze;
      if (do_lu  && sat_inc_ok(m_lu)) m_lu = m_lu + 1;
      if (freeze && sat_inc_ok(m_mw)) m_mw = m_mw + 1;
      if (do_br  && sat_inc_ok(m_fl)) m_fl = m_fl + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{stall_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex, f_exmem, f_memwb,
            tmo, c_lu, c_mw, c_fl};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d outputs: got %h expected %h (t=%0t)", vectors, a, e, $time);
      end
    end
  end

  initial begin
    // reset
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    // load-use: add x6,x5,x5 behind a load to x5, then the bubble releases
    cyc(1'b1, 32'h0052_8333, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0052_8333, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // x0 destination never stalls
    cyc(1'b1, 32'h0000_0013, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    // branch together with a load-use: squash wins
    cyc(1'b1, 32'h0052_8333, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(1);
    // memory wait of 4 cycles, release on ready (watchdog trips at 3)
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // reset mid-stall
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // watchdog: boundary just below the limit, then held past it, then sticky
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          mk_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
          ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 7)),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 9) < 6));
    end
    idle(1);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the stall_disable and flush inputs of the IFID, IDEX, EXMEM and MEMWB pipeline registers, plus a PC hold.
- Resolves load-use hazards with a one-bubble stall.
- Resolves taken branches/jumps by squashing the wrong-path instructions.
- Freezes the pipeline while data memory is not ready, through a small FSM with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles after which memTimeout_out sets (must be >=1)
XLEN, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instruction_IFID_in  in  XLEN  instruction in decode; rs1=[19:15], rs2=[24:20]
memRead_IDEX_in  in  1  instruction in EX is a load
rd_IDEX_in  in  5  destination register of EX instruction
branchTaken_EX_in  in  1  taken branch or jump resolved in EX this cycle
memReq_EXMEM_in  in  1  load/store occupying MEM stage
memReady_in  in  1  data memory completes access this cycle
stallPC_out  out  1  1 = PC holds
stall_disable_IFID_out  out  1  1 = IFID register holds
stall_disable_IDEX_out  out  1  1 = IDEX holds
stall_disable_EXMEM_out  out  1  1 = EXMEM holds
stall_disable_MEMWB_out  out  1  1 = MEMWB holds (always 0; present for uniformity)
flush_IFID_out  out  1  1 = IFID loads bubble
flush_IDEX_out  out  1  1 = IDEX loads bubble
flush_EXMEM_out  out  1  1 = EXMEM loads bubble
flush_MEMWB_out  out  1  1 = MEMWB loads bubble
memTimeout_out  out  1  sticky watchdog flag
cnt_loadUse_out  out  32  load-use bubble count (PERF_CNT_EN)
cnt_memWait_out  out  32  memory stall cycle count (PERF_CNT_EN)
cnt_flush_out  out  32  branch flush count (PERF_CNT_EN)

Behaviour:
- FSM states: RUN, MEM_WAIT. Stall/flush outputs are Mealy: combinational from the current state and the inputs, so they take effect in the same cycle. State, watchdog and counters are registered.
- Reset (rst_n=0 at a clk edge): state=RUN, watchdog=0, memTimeout_out=0, all counters=0.
- While rst_n=0: all flush_* outputs = 1 and all stall outputs = 0, so the pipeline fills with bubbles.
- Load-use hazard (lu) = memRead_IDEX_in && rd_IDEX_in!=0 && (rd_IDEX_in==rs1 || rd_IDEX_in==rs2). Both sources are compared for every opcode; false stalls are acceptable.
- Memory stall (ms) = memReq_EXMEM_in && !memReady_in.
- Priority is ms > branchTaken_EX_in > lu. The lower-priority events are re-evaluated once the pipeline moves.
- ms response: stallPC, IFID, IDEX and EXMEM held; flush_MEMWB_out=1. State goes RUN->MEM_WAIT on the first ms cycle.
- MEM_WAIT: the same outputs hold while !memReady_in. On memReady_in=1, all stalls drop in that cycle and the next state is RUN.
- An ms cycle in RUN asserts the stall in that cycle; there is no extra latency.
- Watchdog: counts MEM_WAIT cycles, cleared on entry to RUN, saturating. When it reaches MEM_TIMEOUT with memReady_in still 0, memTimeout_out sets and stays set until reset. Stalling continues.
- Branch response: flush_IFID_out=1 and flush_IDEX_out=1. PC is not held, so the redirect target loads. Any lu in the same cycle is ignored because that instruction is squashed.
- lu response (one cycle): stallPC=1, stall_disable_IFID_out=1, flush_IDEX_out=1. The next cycle sees memRead_IDEX_in=0, so the stall self-releases.
- Outputs not named for a case are 0.
- The block never asserts stall and flush on the same register.
- rd=x0 never stalls.

Optional Feature:
PIPE_CTRL_PERF_CNT_EN.
- Defined: the three 32-bit counters increment by 1 per cycle in which lu, ms (while stalled) or a branch flush respectively take effect.
- Counters saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: the ports exist but are tied to 0, and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - RS1_LSB/RS2_LSB/REG_IDX_W constants;
  - the x0 index constant.
- Sub-module pipe_hazard_cmp: purely combinational. It takes the instruction, memRead and rd and outputs lu. It is reused later for forwarding checks.

Test Plan:
- Load-use: memRead_IDEX=1, rd=5, IFID instruction 0x00528333 (add x6,x5,x5) -> one cycle of stallPC=1, stall_IFID=1, flush_IDEX=1; the next cycle all outputs are 0; cnt_loadUse=1.
- x0 case: memRead_IDEX=1, rd=0, rs1=0 -> no stall.
- Branch with simultaneous lu: branchTaken_EX=1 -> flush_IFID=1 and flush_IDEX=1, stallPC=0, no lu stall; cnt_flush=1.
- Memory wait: memReq=1, memReady=0 for 4 cycles, then 1 -> 4 cycles of stalls on PC/IFID/IDEX/EXMEM with flush_MEMWB=1, release in the ready cycle, state back to RUN; cnt_memWait=4.
- Watchdog: MEM_TIMEOUT=3, memReady held at 0 -> memTimeout_out=1 after 3 MEM_WAIT cycles, stays 1 after ready returns, clears only on rst_n=0.
- Reset mid-stall: rst_n=0 during MEM_WAIT -> all flushes=1 and stalls=0 while low; after release, state=RUN and counters=0.
